// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
// The SRAM is 16 bits wide; each port transfer is a 32-bit word split into two halfword cycles.
package ram_arb_pkg;

    localparam int RAM_AW = 18;
    localparam int RAM_DW = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IF  = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one 16-bit asynchronous SRAM.
// Each 32-bit access is two halfword cycles (LO, HI) followed by a one-cycle ack (DONE).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                if_req,
    input  logic [RAM_AW-1:0]   if_addr,
    output logic                if_ack,
    output logic [WORD_W-1:0]   if_rdata,

    input  logic                mem_req,
    input  logic                mem_rw,
    input  logic [RAM_AW-1:0]   mem_addr,
    input  logic [WORD_W-1:0]   mem_wdata,
    output logic                mem_ack,
    output logic [WORD_W-1:0]   mem_rdata,

    output logic [RAM_AW-1:0]   ram_addr,
    output logic [RAM_DW-1:0]   ram_wdata,
    input  logic [RAM_DW-1:0]   ram_rdata,
    output logic                ram_drive,
    output logic                ram_wre
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t              state;
    owner_t              owner;
    logic                rw;
    logic [RAM_AW-2:0]   word_addr;
    logic [WORD_W-1:0]   wdata;
    logic [RAM_DW-1:0]   lo_half;
    logic [CW-1:0]       starve;

    logic                grant_if;
    logic                sel_rw;
    logic [RAM_AW-1:0]   sel_addr;

    // Halfword select bit of the request addresses is intentionally ignored.
    logic                unused_addr_lsb;
    assign unused_addr_lsb = if_addr[0] ^ mem_addr[0];

    always_comb begin
        grant_if = if_req && (!mem_req || (starve == LIMIT));
        sel_rw   = grant_if ? 1'b0 : mem_rw;
        sel_addr = grant_if ? if_addr : mem_addr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_MEM;
            rw        <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
            lo_half   <= '0;
            starve    <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_drive <= 1'b0;
            ram_wre   <= 1'b1;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Starvation count only tracks mem grants while a fetch is waiting.
                    if (!if_req || grant_if)
                        starve <= '0;
                    else if (mem_req && (starve != LIMIT))
                        starve <= starve + 1'b1;

                    if (if_req || mem_req) begin
                        owner     <= grant_if ? OWN_IF : OWN_MEM;
                        rw        <= sel_rw;
                        word_addr <= sel_addr[RAM_AW-1:1];
                        wdata     <= mem_wdata;
                        ram_addr  <= {sel_addr[RAM_AW-1:1], 1'b0};
                        ram_wdata <= mem_wdata[RAM_DW-1:0];
                        ram_drive <= sel_rw;
                        ram_wre   <= ~sel_rw;
                        state     <= ST_LO;
                    end
                end

                ST_LO: begin
                    if (!rw)
                        lo_half <= ram_rdata;
                    ram_addr  <= {word_addr, 1'b1};
                    ram_wdata <= wdata[WORD_W-1:RAM_DW];
                    state     <= ST_HI;
                end

                ST_HI: begin
                    ram_drive <= 1'b0;
                    ram_wre   <= 1'b1;
                    if (owner == OWN_IF) begin
                        if_ack   <= 1'b1;
                        if_rdata <= {ram_rdata, lo_half};
                    end else begin
                        mem_ack <= 1'b1;
                        if (!rw)
                            mem_rdata <= {ram_rdata, lo_half};
                    end
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural SRAM attached to the RAM side.
module tb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_rw;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_drive;
    logic        ram_wre;

    int checks;
    int errors;

    logic [15:0] sram   [0:1023];
    logic [15:0] shadow [0:255];
    logic        wre_bad;

    ram_arbiter #(.STARVE_LIMIT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_drive (ram_drive),
        .ram_wre   (ram_wre)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ram_rdata = sram[ram_addr[9:0]];

    always @(posedge clock) begin
        if (ram_wre === 1'b0)
            sram[ram_addr[9:0]] <= ram_wdata;
    end

    always @(negedge clock) begin
        if (ram_wre === 1'b0 && ram_drive !== 1'b1)
            wre_bad <= 1'b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({if_ack, mem_ack, ram_drive, ram_wre} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: got ack_if=%b ack_mem=%b drive=%b wre=%b, want 0 0 0 1",
                     if_ack, mem_ack, ram_drive, ram_wre);
        end
        checks++;
        if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got if=%h mem=%h, want 0 0", if_rdata, mem_rdata);
        end
        checks++;
        if (ram_addr !== 18'h0 || ram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_ram: got addr=%h wdata=%h, want 0 0", ram_addr, ram_wdata);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mem_write();
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 18'h00010; mem_wdata = 32'hDEADBEEF;
        step();  // grant -> LO
        checks++;
        if (ram_addr !== 18'h00010 || ram_wdata !== 16'hBEEF || ram_wre !== 1'b0 || ram_drive !== 1'b1) begin
            errors++;
            $display("FAIL write_lo: got addr=%h wdata=%h wre=%b drive=%b, want 00010 beef 0 1",
                     ram_addr, ram_wdata, ram_wre, ram_drive);
        end
        step();  // HI
        checks++;
        if (ram_addr !== 18'h00011 || ram_wdata !== 16'hDEAD || ram_wre !== 1'b0 || mem_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_hi: got addr=%h wdata=%h wre=%b ack=%b, want 00011 dead 0 0",
                     ram_addr, ram_wdata, ram_wre, mem_ack);
        end
        step();  // DONE
        checks++;
        if (mem_ack !== 1'b1 || if_ack !== 1'b0 || ram_wre !== 1'b1 || ram_drive !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: got mem_ack=%b if_ack=%b wre=%b drive=%b, want 1 0 1 0",
                     mem_ack, if_ack, ram_wre, ram_drive);
        end
        mem_req = 1'b0;
        step();  // IDLE
        checks++;
        if (mem_ack !== 1'b0 || sram[16] !== 16'hBEEF || sram[17] !== 16'hDEAD) begin
            errors++;
            $display("FAIL write_mem: got ack=%b ram10=%h ram11=%h, want 0 beef dead",
                     mem_ack, sram[16], sram[17]);
        end
    endtask

    task automatic test_if_read();
        logic saw_write;
        saw_write = 1'b0;
        sram[16] = 16'h1234;
        sram[17] = 16'h5678;
        if_req = 1'b1; if_addr = 18'h00011;
        step();  // LO
        if_addr = 18'h00200;  // must not disturb the access already granted
        checks++;
        if (ram_addr !== 18'h00010) begin
            errors++;
            $display("FAIL read_lo_addr: got %h, want 00010", ram_addr);
        end
        if (ram_wre !== 1'b1 || ram_drive !== 1'b0) saw_write = 1'b1;
        step();  // HI
        checks++;
        if (ram_addr !== 18'h00011) begin
            errors++;
            $display("FAIL read_hi_addr: got %h, want 00011", ram_addr);
        end
        if (ram_wre !== 1'b1 || ram_drive !== 1'b0) saw_write = 1'b1;
        step();  // DONE
        if (ram_wre !== 1'b1 || ram_drive !== 1'b0) saw_write = 1'b1;
        checks++;
        if (if_ack !== 1'b1 || mem_ack !== 1'b0 || if_rdata !== 32'h56781234) begin
            errors++;
            $display("FAIL read_ack: got if_ack=%b mem_ack=%b rdata=%h, want 1 0 56781234",
                     if_ack, mem_ack, if_rdata);
        end
        checks++;
        if (saw_write !== 1'b0) begin
            errors++;
            $display("FAIL read_wre: got write activity=%b, want 0", saw_write);
        end
        if_req = 1'b0;
        step();
        checks++;
        if (if_ack !== 1'b0 || if_rdata !== 32'h56781234) begin
            errors++;
            $display("FAIL read_hold: got ack=%b rdata=%h, want 0 56781234", if_ack, if_rdata);
        end
    endtask

    task automatic test_contention();
        int mem_t;
        int if_t;
        mem_t = -1; if_t = -1;
        sram[32] = 16'h1111;
        sram[33] = 16'h2222;
        if_req = 1'b1; if_addr = 18'h00010;
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 18'h00020;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (mem_ack === 1'b1) begin
                mem_t = i;
                mem_req = 1'b0;
                checks++;
                if (mem_rdata !== 32'h22221111) begin
                    errors++;
                    $display("FAIL contend_mem_rdata: got %h, want 22221111", mem_rdata);
                end
            end
            if (if_ack === 1'b1 && if_t < 0) begin
                if_t = i;
                if_req = 1'b0;
            end
        end
        checks++;
        if (mem_t != 3 || if_t != 7) begin
            errors++;
            $display("FAIL contend_order: got mem_ack@%0d if_ack@%0d, want 3 7", mem_t, if_t);
        end
    endtask

    task automatic test_starvation();
        string got;
        int    acks;
        got = "";
        acks = 0;
        sram[32] = 16'h1111;
        sram[33] = 16'h2222;
        if_req = 1'b1; if_addr = 18'h00010;
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 18'h00020;
        for (int i = 0; i < 40 && acks < 6; i++) begin
            step();
            if (if_ack === 1'b1 && mem_ack === 1'b1) begin
                got = {got, "B"};
                acks++;
            end else if (if_ack === 1'b1) begin
                got = {got, "I"};
                acks++;
            end else if (mem_ack === 1'b1) begin
                got = {got, "M"};
                acks++;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        checks++;
        if (got != "MMIMMI") begin
            errors++;
            $display("FAIL starve_order: got %s, want MMIMMI", got);
        end
        step();
    endtask

    task automatic test_reset_mid_write();
        sram[64] = 16'h0000;
        sram[65] = 16'h0000;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 18'h00040; mem_wdata = 32'hCAFEF00D;
        step();  // LO
        step();  // HI
        reset = 1'b1;
        mem_req = 1'b0;
        step();
        checks++;
        if (ram_wre !== 1'b1 || ram_drive !== 1'b0 || mem_ack !== 1'b0 || if_ack !== 1'b0 || ram_addr !== 18'h0) begin
            errors++;
            $display("FAIL abort_state: got wre=%b drive=%b mem_ack=%b if_ack=%b addr=%h, want 1 0 0 0 0",
                     ram_wre, ram_drive, mem_ack, if_ack, ram_addr);
        end
        reset = 1'b0;
        step();
        step();
        step();
        checks++;
        if (mem_ack !== 1'b0 || sram[64] !== 16'hF00D) begin
            errors++;
            $display("FAIL abort_noack: got mem_ack=%b ram40=%h, want 0 f00d", mem_ack, sram[64]);
        end
        // The HI halfword was driven for its whole cycle before reset, so it landed too.
        if_req = 1'b1; if_addr = 18'h00040;
        for (int i = 0; i < 8; i++) begin
            step();
            if (if_ack === 1'b1) begin
                if_req = 1'b0;
                break;
            end
        end
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL abort_reread: got ack=%b rdata=%h, want 1 cafef00d", if_ack, if_rdata);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic        port_if;
        logic        rw;
        logic [17:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  lo_i;
        logic [7:0]  hi_i;
        int          acks;
        int          wrong;
        int          lat;
        for (int i = 0; i < 256; i++) shadow[i] = sram[i];
        for (int n = 0; n < 16; n++) begin
            port_if = 1'($urandom_range(0, 1));
            rw      = port_if ? 1'b0 : 1'($urandom_range(0, 1));
            a       = 18'($urandom_range(0, 255));
            wd      = $urandom;
            lo_i    = {a[7:1], 1'b0};
            hi_i    = {a[7:1], 1'b1};
            exp_rd  = {shadow[hi_i], shadow[lo_i]};
            if (rw) begin
                shadow[lo_i] = wd[15:0];
                shadow[hi_i] = wd[31:16];
            end
            if (port_if) begin
                if_req = 1'b1; if_addr = a;
            end else begin
                mem_req = 1'b1; mem_rw = rw; mem_addr = a; mem_wdata = wd;
            end
            acks = 0; wrong = 0; lat = 0;
            for (int c = 1; c <= 6; c++) begin
                step();
                if ((port_if ? mem_ack : if_ack) === 1'b1) wrong++;
                if ((port_if ? if_ack : mem_ack) === 1'b1) begin
                    acks++;
                    lat = c;
                    if_req = 1'b0;
                    mem_req = 1'b0;
                    if (!rw) begin
                        checks++;
                        if ((port_if ? if_rdata : mem_rdata) !== exp_rd) begin
                            errors++;
                            $display("FAIL rand_data[%0d]: got %h, want %h at addr %h",
                                     n, port_if ? if_rdata : mem_rdata, exp_rd, a);
                        end
                    end
                end
            end
            if_req = 1'b0;
            mem_req = 1'b0;
            checks++;
            if (acks != 1 || wrong != 0 || lat != 3) begin
                errors++;
                $display("FAIL rand_ack[%0d]: got acks=%0d wrong_port=%0d latency=%0d, want 1 0 3",
                         n, acks, wrong, lat);
            end
        end
        checks++;
        if (wre_bad !== 1'b0) begin
            errors++;
            $display("FAIL wre_without_drive: got %b, want 0", wre_bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wre_bad = 1'b0;
        for (int i = 0; i < 1024; i++) sram[i] = 16'(i * 3);
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_wdata = '0;

        test_reset();
        test_mem_write();
        test_if_read();
        test_contention();
        step();
        test_starvation();
        test_reset_mid_write();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
